axi_write_master: RTL and testbench

AXI4 write-burst master that sits directly upstream of the AXI write slave and drives its AW, W and B channels. It accepts one burst command at a time (start address, beat count), issues the address phase, and streams beats from a local data source onto the W channel with a correct `wlast`. It then collects the write response and reports completion and error status to the command issuer.

---
 rtl/axi_write_master.sv | 158 +++++++++++++++
 tb/tb_axi_write_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_master.sv
// rtl/axi_write_master.sv - AXI4 write-burst master: one command in, AW/W/B out, done/err back.
// Optional B-channel timeout is built when AXI_WM_TIMEOUT_EN is defined.
module axi_write_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [DATA_WIDTH-1:0]     src_data,
  input  logic [DATA_WIDTH/8-1:0]   src_strb,
  input  logic                      src_valid,
  output logic                      src_ready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic                      done,
  output logic                      err
);

  localparam logic [2:0] AWSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state, state_nxt;
  logic [7:0] beat_cnt;
  logic       ready_q;
  logic       cmd_hs;
  logic       w_hs;
  logic       b_hs;
  logic       last_beat;
  logic       to_hit;

  assign cmd_hs    = cmd_valid && ready_q;
  assign last_beat = (beat_cnt == awlen);
  assign w_hs      = (state == DATA) && src_valid && wready;
  assign b_hs      = (state == RESP) && bvalid;

`ifdef AXI_WM_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Fires on the last allowed RESP cycle so the block spends exactly TIMEOUT_CYCLES in RESP.
  assign to_hit = (state == RESP) && !bvalid &&
                  (({16'd0, to_cnt} + 32'd1) >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt <= 16'd0;
    end else if (state == RESP) begin
      to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= 16'd0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    awsize    = 3'd0;
    awburst   = 2'b00;
    wvalid    = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    src_ready = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_hs) state_nxt = ADDR;
      end
      ADDR: begin
        awvalid = 1'b1;
        awsize  = AWSIZE;
        awburst = 2'b01;
        if (awready) state_nxt = DATA;
      end
      DATA: begin
        wvalid    = src_valid;
        src_ready = wready;
        wdata     = src_data;
        wstrb     = src_strb;
        wlast     = last_beat;
        if (w_hs && last_beat) state_nxt = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid || to_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low for the first cycle out of reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_nxt == IDLE);
    end
  end

  assign cmd_ready = ready_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr   <= '0;
      awlen    <= 8'd0;
      beat_cnt <= 8'd0;
    end else if (cmd_hs) begin
      awaddr   <= cmd_addr;
      awlen    <= cmd_len;
      beat_cnt <= 8'd0;
    end else if (w_hs && !last_beat) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= b_hs || to_hit;
      if (b_hs) begin
        err <= (bresp != 2'b00);
      end else if (to_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_write_master.sv
// tb/tb_axi_write_master.sv - directed self-checking bench for axi_write_master (default build).
module tb_axi_write_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] src_data;
  logic [1:0]  src_strb;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [15:0] wdata;
  logic [1:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axi_write_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .src_data(src_data), .src_strb(src_strb), .src_valid(src_valid), .src_ready(src_ready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge aclk);
    #1;
  endtask

  // Zero-wait W burst with data base+beat, optional AW stall, then B with the given response.
  task automatic burst(input logic [7:0] a, input logic [7:0] len, input logic [1:0] br,
                       input int aw_wait, input logic [15:0] base);
    adv();
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = len;
    awready = (aw_wait == 0); wready = 1'b1; src_valid = 1'b1;
    src_data = base; src_strb = 2'b11; bvalid = 1'b1; bresp = br;
    @(negedge aclk);
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    adv();
    cmd_valid = 1'b0;
    @(negedge aclk);
    chk("aw_valid", 32'(awvalid), 32'd1);
    chk("aw_addr", 32'(awaddr), 32'(a));
    chk("aw_len", 32'(awlen), 32'(len));
    chk("aw_size", 32'(awsize), 32'd1);
    chk("aw_burst", 32'(awburst), 32'd1);
    chk("no_w_before_aw", 32'(wvalid), 32'd0);
    for (int i = 1; i <= aw_wait; i++) begin
      adv();
      if (i == aw_wait) awready = 1'b1;
      @(negedge aclk);
      chk("aw_hold_valid", 32'(awvalid), 32'd1);
      chk("aw_hold_addr", 32'(awaddr), 32'(a));
      chk("aw_hold_len", 32'(awlen), 32'(len));
      chk("aw_hold_no_w", 32'(wvalid), 32'd0);
    end
    for (int b = 0; b <= int'(len); b++) begin
      adv();
      src_data = 16'(base + 16'(b));
      @(negedge aclk);
      chk("beat_wvalid", 32'(wvalid), 32'd1);
      chk("beat_wdata", 32'(wdata), 32'(16'(base + 16'(b))));
      chk("beat_wstrb", 32'(wstrb), 32'd3);
      chk("beat_wlast", 32'(wlast), 32'(b == int'(len)));
      chk("beat_awvalid_low", 32'(awvalid), 32'd0);
    end
    adv();
    @(negedge aclk);
    chk("resp_bready", 32'(bready), 32'd1);
    chk("resp_wvalid_low", 32'(wvalid), 32'd0);
    adv();
    @(negedge aclk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("err_value", 32'(err), 32'(br != 2'b00));
    chk("ready_after_done", 32'(cmd_ready), 32'd1);
    adv();
    bvalid = 1'b0;
    @(negedge aclk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] d [4];
    int idx;
    int hs;
    int cyc;
    logic [15:0] prev_data;
    logic prev_stall;

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = 8'd0; cmd_len = 8'd0;
    src_data = 16'd0; src_strb = 2'd0; src_valid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    adv();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("release_ready_low", 32'(cmd_ready), 32'd0);
    adv();
    @(negedge aclk);
    chk("release_ready_high", 32'(cmd_ready), 32'd1);

    // single beat, zero-wait, OKAY
    burst(8'h10, 8'd0, 2'b00, 0, 16'hA5A5);

    // 4-beat burst with wready toggling and source gaps
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
    adv();
    cmd_valid = 1'b1; cmd_addr = 8'h40; cmd_len = 8'd3; awready = 1'b1;
    src_valid = 1'b0; wready = 1'b0; bvalid = 1'b0;
    adv();
    cmd_valid = 1'b0;
    @(negedge aclk);
    chk("b4_awvalid", 32'(awvalid), 32'd1);
    idx = 0; hs = 0; cyc = 0; prev_stall = 1'b0; prev_data = 16'd0;
    while (!bready && cyc < 40) begin
      adv();
      src_valid = (idx < 4) && ((cyc % 3) != 2);
      wready    = (cyc % 2) == 1;
      src_data  = (idx < 4) ? d[idx] : 16'hDEAD;
      src_strb  = 2'b11;
      @(negedge aclk);
      if (!bready) begin
        chk("b4_wvalid_follows", 32'(wvalid), 32'(src_valid));
        chk("b4_src_ready_follows", 32'(src_ready), 32'(wready));
        if (prev_stall) chk("b4_stall_stable", 32'(wdata), 32'(prev_data));
        if (wvalid && wready) begin
          chk("b4_data_order", 32'(wdata), 32'(d[idx]));
          chk("b4_wlast", 32'(wlast), 32'(idx == 3));
          idx++;
          hs++;
        end else if (wvalid) begin
          chk("b4_wlast_stall", 32'(wlast), 32'(idx == 3));
        end
        prev_stall = wvalid && !wready;
        prev_data  = wdata;
      end
      cyc++;
    end
    chk("b4_reached_resp", 32'(bready), 32'd1);
    chk("b4_handshakes", 32'(hs), 32'd4);
    bvalid = 1'b1; bresp = 2'b00;
    adv();
    @(negedge aclk);
    chk("b4_done", 32'(done), 32'd1);
    chk("b4_err", 32'(err), 32'd0);
    adv();
    bvalid = 1'b0;

    // AW stalled 5 cycles, 2 beats, SLVERR -> err=1
    burst(8'h80, 8'd1, 2'b10, 5, 16'h0100);
    // next burst OKAY clears err
    burst(8'h22, 8'd0, 2'b00, 0, 16'h0200);
    // DECERR sets err again before the reset check
    burst(8'h33, 8'd0, 2'b11, 0, 16'h0300);
    chk("err_held", 32'(err), 32'd1);

    // reset mid-DATA
    adv();
    cmd_valid = 1'b1; cmd_addr = 8'h20; cmd_len = 8'd2; awready = 1'b1;
    wready = 1'b0; src_valid = 1'b1; src_data = 16'hBEEF;
    adv();
    cmd_valid = 1'b0;
    adv();
    @(negedge aclk);
    chk("pre_rst_wvalid", 32'(wvalid), 32'd1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("arst_wvalid", 32'(wvalid), 32'd0);
    chk("arst_wdata", 32'(wdata), 32'd0);
    chk("arst_awaddr", 32'(awaddr), 32'd0);
    chk("arst_awlen", 32'(awlen), 32'd0);
    chk("arst_awsize", 32'(awsize), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_bready", 32'(bready), 32'd0);
    adv();
    adv();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel2_ready_low", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      adv();
      @(negedge aclk);
      chk("rel2_ready_high", 32'(cmd_ready), 32'd1);
      chk("rel2_no_done", 32'(done), 32'd0);
    end

    burst(8'hF0, 8'd1, 2'b00, 0, 16'h0400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
